fifo_sync_param: RTL and testbench

- Parametrised synchronous FIFO. It is the next generation of the fixed 16x16 FIFO, generalised in data width and depth.
- Adds the following:
  - programmable almost-full and almost-empty flags
  - an occupancy level output
  - a read-data valid strobe
  - a synchronous flush
  - sticky overflow and underflow error flags
  - write-through when full if a read is accepted in the same cycle
- Used as the generic single-clock buffer between datapath stages in the design.

---
 rtl/fifo_sync_param.sv | 137 +++++++++++++
 tb/tb_fifo_sync_param.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy level,
// almost-full/almost-empty flags, sticky overflow/underflow and flush.
//
// Parameters:
//   DATA_W    - data word width in bits (>=1)
//   DEPTH     - number of entries (power of 2, >=2)
//   ADDR_W    - pointer width, derived from DEPTH (do not override)
//   AF_THRESH - almost_full when level >= AF_THRESH (1..DEPTH)
//   AE_THRESH - almost_empty when level <= AE_THRESH (0..DEPTH-1)
//
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   flush        - synchronous clear of contents and error flags
//   wr_en, data_in    - write request and write data
//   rd_en             - read request (pop/acknowledge in FWFT mode)
//   data_out, valid_out - read data and its valid strobe
//   full, empty, almost_full, almost_empty, level - status
//   overflow, underflow - sticky rejected-write / rejected-read flags
//
// Build option:
//   FIFO_FWFT_EN - first-word fall-through: data_out shows the head
//                  word combinationally and valid_out = !empty.
//                  Undefined: registered data_out, 1-cycle latency.

module fifo_sync_param #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  // Status is decoded from the registered level only.
  assign full         = (level == DEPTH_L);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  // Flush wins over both requests. A full FIFO still takes a write
  // when a read frees a slot in the same cycle; an empty FIFO never
  // bypasses a write to the read side.
  assign rd_acc = rd_en && !empty && !flush;
  assign wr_acc = wr_en && (!full || rd_acc) && !flush;

  // Storage is not reset; contents are only meaningful via level.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN

  // Head word is presented as soon as it is stored.
  assign data_out  = mem[rd_ptr];
  assign valid_out = !empty;

`else

  // Registered read port; data_out keeps the last word read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_acc;
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed and randomized checks of fifo_sync_param
// against a queue-based model of the FIFO rules.

module tb_fifo_sync_param;

  localparam int DW = 16;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          underflow;

  int tests = 0;
  int fails = 0;
  bit run_chk = 1'b0;

  fifo_sync_param #(
    .DATA_W(DW),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .wr_en(wr_en),
    .data_in(data_in),
    .rd_en(rd_en),
    .data_out(data_out),
    .valid_out(valid_out),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .level(level),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Model: contents as a queue plus sticky flags and read port.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_valid = 1'b0;
  bit            m_of = 1'b0;
  bit            m_uf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit ra;
    bit wa;
    if (!rst_n) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_of    = 1'b0;
      m_uf    = 1'b0;
    end else if (flush) begin
      q.delete();
      m_valid = 1'b0;
      m_of    = 1'b0;
      m_uf    = 1'b0;
    end else begin
      ra = rd_en && (q.size() != 0);
      wa = wr_en && ((q.size() < D) || ra);
      if (rd_en && !ra) m_uf = 1'b1;
      if (wr_en && !wa) m_of = 1'b1;
      m_valid = ra;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(data_in);
    end
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("level", 32'(level), q.size());
      chk("full", 32'(full), 32'(q.size() == D));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
      chk("overflow", 32'(overflow), 32'(m_of));
      chk("underflow", 32'(underflow), 32'(m_uf));
`ifdef FIFO_FWFT_EN
      chk("valid_out", 32'(valid_out), 32'(q.size() != 0));
      if (q.size() != 0) chk("data_out", 32'(data_out), 32'(q[0]));
`else
      chk("valid_out", 32'(valid_out), 32'(m_valid));
      chk("data_out", 32'(data_out), 32'(m_dout));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pw;
    int pr;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_chk = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_valid", 32'(valid_out), 0);

`ifndef FIFO_FWFT_EN
    wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      data_in = DW'(i);
      cyc();
      chk("fill_level", 32'(level), i);
      if (i == 13) chk("af_13", 32'(almost_full), 0);
      if (i == 14) chk("af_14", 32'(almost_full), 1);
    end
    chk("fill_full", 32'(full), 1);
    data_in = 16'hFFFF;
    cyc();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 16);

    data_in = 16'hAAAA;
    rd_en = 1'b1;
    cyc();
    chk("wt_dout", 32'(data_out), 32'h0001);
    chk("wt_valid", 32'(valid_out), 1);
    chk("wt_level", 32'(level), 16);
    wr_en = 1'b0;
    repeat (16) cyc();
    chk("wt_last", 32'(data_out), 32'hAAAA);
    chk("wt_empty", 32'(empty), 1);

    wr_en = 1'b1;
    data_in = 16'h1234;
    cyc();
    chk("emp_uf", 32'(underflow), 1);
    chk("emp_level", 32'(level), 1);
    chk("emp_valid", 32'(valid_out), 0);
    wr_en = 1'b0;
    cyc();
    chk("emp_dout", 32'(data_out), 32'h1234);
    chk("emp_valid2", 32'(valid_out), 1);
    rd_en = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_uf", 32'(underflow), 0);

    for (int r = 0; r < 2; r++) begin
      wr_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
        data_in = DW'(32'h100 + r * 10 + k);
        cyc();
      end
      wr_en = 1'b0;
      rd_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
        cyc();
        chk("wrap_data", 32'(data_out), 32'h100 + r * 10 + k);
        chk("wrap_valid", 32'(valid_out), 1);
      end
      rd_en = 1'b0;
    end
    chk("wrap_empty", 32'(empty), 1);
    chk("wrap_ae", 32'(almost_empty), 1);

    wr_en = 1'b1;
    repeat (17) cyc();
    chk("of2_set", 32'(overflow), 1);
    flush = 1'b1;
    data_in = 16'hBEEF;
    cyc();
    flush = 1'b0;
    wr_en = 1'b0;
    chk("fl_level", 32'(level), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_ovf", 32'(overflow), 0);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("fl_nostore", 32'(valid_out), 0);
    chk("fl_uf2", 32'(underflow), 1);
`else
    wr_en = 1'b1;
    data_in = 16'h00AA;
    cyc();
    wr_en = 1'b0;
    chk("fw_dout", 32'(data_out), 32'h00AA);
    chk("fw_valid", 32'(valid_out), 1);
    cyc();
    chk("fw_hold", 32'(valid_out), 1);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("fw_empty", 32'(empty), 1);
    chk("fw_valid0", 32'(valid_out), 0);
    wr_en = 1'b1;
    data_in = 16'h0011;
    cyc();
    data_in = 16'h0022;
    rd_en = 1'b1;
    cyc();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("fw_next", 32'(data_out), 32'h0022);
    chk("fw_lvl", 32'(level), 1);
`endif

    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin pw = 70; pr = 30; end
        1: begin pw = 30; pr = 70; end
        2: begin pw = 50; pr = 50; end
        default: begin pw = 90; pr = 90; end
      endcase
      for (int n = 0; n < 600; n++) begin
        wr_en = ($urandom % 100) < pw;
        rd_en = ($urandom % 100) < pr;
        data_in = DW'($urandom);
        flush = ($urandom % 200) == 0;
        cyc();
      end
    end
    flush = 1'b0;
    rd_en = 1'b0;

    wr_en = 1'b1;
    repeat (5) cyc();
    rd_en = 1'b1;
    repeat (3) cyc();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_valid", 32'(valid_out), 0);
    chk("arst_empty", 32'(empty), 1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    wr_en = 1'b1;
    data_in = 16'h5A5A;
    cyc();
    wr_en = 1'b0;
`ifndef FIFO_FWFT_EN
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
`endif
    chk("post_rst_dout", 32'(data_out), 32'h5A5A);
    chk("post_rst_valid", 32'(valid_out), 1);
    cyc();
    run_chk = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
